// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Power-up / recovery sequencer for the 12 MHz -> 25.125 MHz PLL.
//            Holds the PLL in reset, waits for LOCK with a timeout and a
//            bounded number of retries, qualifies lock stability, and only
//            then releases the system reset. Loss of lock while running
//            re-enters the sequence. Runs entirely on the reference clock.
// Ports    : ref_clk_i    - 12 MHz reference clock (only clock)
//            rst_n_i      - asynchronous active-low reset
//            pll_lock_i   - raw PLL LOCK (asynchronous, synchronized here)
//            restart_i    - single-cycle restart request, highest priority
//            pll_resetb_o - PLL RESETB, low holds the PLL in reset
//            sys_rst_n_o  - active-low system reset, high only in RUN
//            ready_o      - high only in RUN
//            fail_o       - high only in FAIL
//            retry_cnt_o  - failed attempts since last RUN or restart
//            state_o      - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       ref_clk_i,
    input  logic       rst_n_i,
    input  logic       pll_lock_i,
    input  logic       restart_i,
    output logic       pll_resetb_o,
    output logic       sys_rst_n_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] c_st_pll_rst   = 3'd0;
    localparam logic [2:0] c_st_wait_lock = 3'd1;
    localparam logic [2:0] c_st_stable    = 3'd2;
    localparam logic [2:0] c_st_run       = 3'd3;
    localparam logic [2:0] c_st_fail      = 3'd4;

    // One shared counter must span the longest of the three timed phases.
    localparam int c_cnt_max_a = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int c_cnt_max   = (c_cnt_max_a > STABLE_CYCLES) ? c_cnt_max_a : STABLE_CYCLES;
    localparam int c_cnt_w     = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_reset_last   = c_cnt_w'(RESET_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [1:0]         c_max_retries  = 2'(MAX_RETRIES);

    logic               r_sync1;
    logic               r_lock_s;
    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_retry;
    logic               r_pll_resetb;
    logic               r_sys_rst_n;
    logic               r_ready;
    logic               r_fail;

    logic [2:0]         w_state_nxt;
    logic [1:0]         w_retry_nxt;
    logic [1:0]         w_retry_inc;
    logic               w_fail_att;
    logic               w_cnt_clr;

    // ------------------------------------------------------------------------
    // Next-state / retry bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_fail_att  = 1'b0;
        w_retry_inc = (r_retry == 2'd3) ? 2'd3 : r_retry + 2'd1;

        if (restart_i) begin
            // Restart overrides any same-cycle timeout or RUN entry.
            w_state_nxt = c_st_pll_rst;
            w_retry_nxt = 2'd0;
        end else begin
            case (r_state)
                c_st_pll_rst: begin
                    if (r_cnt == c_reset_last) w_state_nxt = c_st_wait_lock;
                end
                c_st_wait_lock: begin
                    if (r_lock_s)                    w_state_nxt = c_st_stable;
                    else if (r_cnt == c_timeout_last) w_fail_att = 1'b1;
                end
                c_st_stable: begin
                    if (!r_lock_s) begin
                        w_fail_att = 1'b1;
                    end else if (r_cnt == c_stable_last) begin
                        w_state_nxt = c_st_run;
                        w_retry_nxt = 2'd0;
                    end
                end
                c_st_run: begin
                    // Losing lock after a good bring-up is not an attempt failure.
                    if (!r_lock_s) w_state_nxt = c_st_pll_rst;
                end
                c_st_fail: begin
                    w_state_nxt = c_st_fail;
                end
                default: begin
                    w_state_nxt = c_st_pll_rst;
                end
            endcase

            if (w_fail_att) begin
                w_retry_nxt = w_retry_inc;
                w_state_nxt = (w_retry_inc == c_max_retries) ? c_st_fail : c_st_pll_rst;
            end
        end

        // Counter restarts on every state entry, including a restart re-entry.
        w_cnt_clr = restart_i || (w_state_nxt != r_state);
    end

    // ------------------------------------------------------------------------
    // State, counter, synchronizer and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge ref_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1      <= 1'b0;
            r_lock_s     <= 1'b0;
            r_state      <= c_st_pll_rst;
            r_cnt        <= '0;
            r_retry      <= 2'd0;
            r_pll_resetb <= 1'b0;
            r_sys_rst_n  <= 1'b0;
            r_ready      <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_sync1  <= pll_lock_i;
            r_lock_s <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_retry  <= w_retry_nxt;
            // Outputs decode the next state so they move with state_o.
            r_pll_resetb <= (w_state_nxt == c_st_wait_lock) ||
                            (w_state_nxt == c_st_stable)    ||
                            (w_state_nxt == c_st_run);
            r_sys_rst_n  <= (w_state_nxt == c_st_run);
            r_ready      <= (w_state_nxt == c_st_run);
            r_fail       <= (w_state_nxt == c_st_fail);
        end
    end

    assign pll_resetb_o = r_pll_resetb;
    assign sys_rst_n_o  = r_sys_rst_n;
    assign ready_o      = r_ready;
    assign fail_o       = r_fail;
    assign retry_cnt_o  = r_retry;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Purpose  : Self-checking bench for pll_reset_sequencer. A behavioural model
//            tracks elapsed time in each phase from edge numbers and a
//            two-edge-delayed view of LOCK; a compare process checks every
//            output against it on each falling edge, and directed scenarios
//            pin specific edges with literal values.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int RESET_CYCLES  = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    logic       r_ref_clk  = 1'b0;
    logic       r_rst_n    = 1'b1;
    logic       r_pll_lock = 1'b0;
    logic       r_restart  = 1'b0;
    logic       w_pll_resetb;
    logic       w_sys_rst_n;
    logic       w_ready;
    logic       w_fail;
    logic [1:0] w_retry_cnt;
    logic [2:0] w_state;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit r_cmp_en = 1'b0;

    pll_reset_sequencer #(
        .RESET_CYCLES  (RESET_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) u_dut (
        .ref_clk_i    (r_ref_clk),
        .rst_n_i      (r_rst_n),
        .pll_lock_i   (r_pll_lock),
        .restart_i    (r_restart),
        .pll_resetb_o (w_pll_resetb),
        .sys_rst_n_o  (w_sys_rst_n),
        .ready_o      (w_ready),
        .fail_o       (w_fail),
        .retry_cnt_o  (w_retry_cnt),
        .state_o      (w_state)
    );

    always #5 r_ref_clk = ~r_ref_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (n_cmp=%0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: phase number, edge of phase entry, retry count.
    // LOCK is seen two edges late; time in phase = edges since entry.
    // ------------------------------------------------------------------------
    int r_edge_no   = 0;
    int r_edge      = 0;
    int r_entry     = 0;
    int r_exp_state = 0;
    int r_exp_retry = 0;
    bit r_lock_d1   = 1'b0;
    bit r_lock_d2   = 1'b0;
    int w_age;
    int w_nxt;
    bit w_attempt_failed;
    bit w_seen_lock;

    initial forever begin
        @(posedge r_ref_clk or negedge r_rst_n);
        if (!r_rst_n) begin
            r_edge_no   = 0;
            r_edge      = 0;
            r_entry     = 0;
            r_exp_state = 0;
            r_exp_retry = 0;
            r_lock_d1   = 1'b0;
            r_lock_d2   = 1'b0;
        end else begin
            r_edge_no++;
            r_edge++;
            w_age            = r_edge - r_entry - 1;
            w_seen_lock      = r_lock_d2;
            w_nxt            = r_exp_state;
            w_attempt_failed = 1'b0;
            if (r_restart) begin
                w_nxt       = 0;
                r_exp_retry = 0;
            end else begin
                if (r_exp_state == 0) begin
                    if (w_age == RESET_CYCLES - 1) w_nxt = 1;
                end else if (r_exp_state == 1) begin
                    if (w_seen_lock) w_nxt = 2;
                    else if (w_age == LOCK_TIMEOUT - 1) w_attempt_failed = 1'b1;
                end else if (r_exp_state == 2) begin
                    if (!w_seen_lock) w_attempt_failed = 1'b1;
                    else if (w_age == STABLE_CYCLES - 1) begin
                        w_nxt       = 3;
                        r_exp_retry = 0;
                    end
                end else if (r_exp_state == 3) begin
                    if (!w_seen_lock) w_nxt = 0;
                end
                if (w_attempt_failed) begin
                    r_exp_retry = (r_exp_retry < 3) ? r_exp_retry + 1 : 3;
                    w_nxt       = (r_exp_retry == MAX_RETRIES) ? 4 : 0;
                end
            end
            if (w_nxt != r_exp_state || r_restart) r_entry = r_edge;
            r_exp_state = w_nxt;
            r_lock_d2   = r_lock_d1;
            r_lock_d1   = r_pll_lock;
        end
    end

    initial forever begin
        @(negedge r_ref_clk);
        if (r_cmp_en) begin
            check("model state_o",      w_state,      r_exp_state);
            check("model retry_cnt_o",  w_retry_cnt,  r_exp_retry);
            check("model pll_resetb_o", w_pll_resetb, (r_exp_state == 1 || r_exp_state == 2 || r_exp_state == 3));
            check("model sys_rst_n_o",  w_sys_rst_n,  (r_exp_state == 3));
            check("model ready_o",      w_ready,      (r_exp_state == 3));
            check("model fail_o",       w_fail,       (r_exp_state == 4));
        end
    end

    // Return on the falling edge that follows rising edge k after reset release.
    task automatic at(input int k);
        while (r_edge_no < k) @(negedge r_ref_clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " state_o"},      w_state,      0);
        check({tag, " pll_resetb_o"}, w_pll_resetb, 0);
        check({tag, " sys_rst_n_o"},  w_sys_rst_n,  0);
        check({tag, " ready_o"},      w_ready,      0);
        check({tag, " fail_o"},       w_fail,       0);
        check({tag, " retry_cnt_o"},  w_retry_cnt,  0);
    endtask

    task automatic do_reset(input logic lk);
        @(negedge r_ref_clk);
        #2;
        r_rst_n    = 1'b0;
        r_restart  = 1'b0;
        r_pll_lock = lk;
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge r_ref_clk);
        #2;
        r_rst_n = 1'b1;
    endtask

    initial begin
        // 1. Clean bring-up with lock tied high
        do_reset(1'b1);
        r_cmp_en = 1'b1;
        at(3);  check("t1 resetb@3", w_pll_resetb, 0); check("t1 state@3", w_state, 0);
        at(4);  check("t1 resetb@4", w_pll_resetb, 1); check("t1 state@4", w_state, 1);
        at(5);  check("t1 state@5", w_state, 2);
        at(12); check("t1 sysrst@12", w_sys_rst_n, 0);
        at(13); check("t1 sysrst@13", w_sys_rst_n, 1); check("t1 ready@13", w_ready, 1);
                check("t1 state@13", w_state, 3);      check("t1 retry@13", w_retry_cnt, 0);

        // 4. Lock loss in RUN, then re-lock
        at(20); r_pll_lock = 1'b0;
        at(22); check("t4 state@22", w_state, 3); check("t4 sysrst@22", w_sys_rst_n, 1);
        at(23); check("t4 state@23", w_state, 0); check("t4 sysrst@23", w_sys_rst_n, 0);
                check("t4 ready@23", w_ready, 0); check("t4 retry@23", w_retry_cnt, 0);
                r_pll_lock = 1'b1;
        at(35); check("t4 state@35", w_state, 2);
        at(36); check("t4 state@36", w_state, 3); check("t4 ready@36", w_ready, 1);

        // 2. Timeout retries into FAIL, then restart out of FAIL
        do_reset(1'b0);
        at(23);  check("t2 state@23", w_state, 1);
        at(24);  check("t2 state@24", w_state, 0); check("t2 retry@24", w_retry_cnt, 1);
        at(47);  check("t2 state@47", w_state, 1); check("t2 retry@47", w_retry_cnt, 1);
        at(48);  check("t2 state@48", w_state, 4); check("t2 fail@48", w_fail, 1);
                 check("t2 resetb@48", w_pll_resetb, 0); check("t2 retry@48", w_retry_cnt, 2);
        at(148); check("t2 state@148", w_state, 4); check("t2 fail@148", w_fail, 1);
                 check("t2 resetb@148", w_pll_resetb, 0); check("t2 sysrst@148", w_sys_rst_n, 0);
                 r_restart = 1'b1;
        at(149); r_restart = 1'b0;
                 check("t5 state@149", w_state, 0); check("t5 fail@149", w_fail, 0);
                 check("t5 retry@149", w_retry_cnt, 0);

        // 3. Unstable lock during qualification
        do_reset(1'b0);
        at(6);  r_pll_lock = 1'b1;
        at(9);  check("t3 state@9", w_state, 2);
        at(11); r_pll_lock = 1'b0;
        at(12); r_pll_lock = 1'b1;
        at(13); check("t3 state@13", w_state, 2);
        at(14); check("t3 state@14", w_state, 0); check("t3 retry@14", w_retry_cnt, 1);
        at(18); check("t3 state@18", w_state, 1); check("t3 retry@18", w_retry_cnt, 1);
        at(19); check("t3 state@19", w_state, 2);
        at(27); check("t3 state@27", w_state, 3); check("t3 retry@27", w_retry_cnt, 0);
                check("t3 ready@27", w_ready, 1);

        // 5b. Restart on the edge that would enter RUN
        do_reset(1'b1);
        at(12); r_restart = 1'b1;
        at(13); r_restart = 1'b0;
                check("t5b state@13", w_state, 0); check("t5b sysrst@13", w_sys_rst_n, 0);
                check("t5b resetb@13", w_pll_resetb, 0); check("t5b retry@13", w_retry_cnt, 0);
        at(26); check("t5b state@26", w_state, 3);

        // 5c. Asynchronous reset mid-STABLE
        do_reset(1'b1);
        at(7);
        @(posedge r_ref_clk);
        #1;
        check("t5c state pre", w_state, 2);
        #2;
        r_rst_n = 1'b0;
        #1;
        check_reset_vals("t5c async");
        @(negedge r_ref_clk);
        #2;
        r_rst_n = 1'b1;
        at(13); check("t5c state@13", w_state, 3);
        at(15);

        r_cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
